// File: rtl/sram_ctl_pkg.sv
// Shared constants, FSM encoding and descriptor layout for the SRAM write path.
// Imported by write_xfer_ctl, port_mux and the descriptor queue.
package sram_ctl_pkg;

  localparam int NUM_PORTS = 16;
  localparam int SEL_W     = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 12;
  localparam int LEN_W     = 8;
  localparam int MAX_LEN   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  port;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              err;
  } pkt_desc_t;

endpackage

// File: rtl/port_mux.sv
// N:1 selector of FIFO head data/valid/eop plus one-hot pop decode.
// Ports: sel, data_in/valid_in/eop_in (per port), pop_en -> data, valid, eop, pop.
module port_mux
  import sram_ctl_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int DW = DATA_W,
  parameter int SW = SEL_W
) (
  input  logic [SW-1:0]   sel,
  input  logic [N*DW-1:0] data_in,
  input  logic [N-1:0]    valid_in,
  input  logic [N-1:0]    eop_in,
  input  logic            pop_en,
  output logic [DW-1:0]   data,
  output logic            valid,
  output logic            eop,
  output logic [N-1:0]    pop
);

  assign data  = data_in[int'(sel)*DW +: DW];
  assign valid = valid_in[sel];
  assign eop   = eop_in[sel];
  assign pop   = pop_en ? (N'(1) << sel) : '0;

endmodule

// File: rtl/write_xfer_ctl.sv
// Locks onto the granted port, pops its FIFO into registered SRAM writes,
// and emits a packet descriptor (port, start addr, length, error) per packet.
// Ports: clk, rst, select, transfering, port_data/valid/eop -> port_pop,
//        sram_we/addr/wdata, busy, pkt_done, pkt_port/addr/len/err.
module write_xfer_ctl
  import sram_ctl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          select,
  input  logic                      transfering,
  input  logic [NUM_PORTS*DATA_W-1:0] port_data,
  input  logic [NUM_PORTS-1:0]      port_valid,
  input  logic [NUM_PORTS-1:0]      port_eop,
  output logic [NUM_PORTS-1:0]      port_pop,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic                      busy,
  output logic                      pkt_done,
  output logic [SEL_W-1:0]          pkt_port,
  output logic [ADDR_W-1:0]         pkt_addr,
  output logic [LEN_W-1:0]          pkt_len,
  output logic                      pkt_err
);

  if (MAX_LEN >= (1 << LEN_W)) begin : g_len_chk
    $error("MAX_LEN does not fit in LEN_W");
  end

  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  xfer_state_t       state;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len;
  logic              err_q;
  pkt_desc_t         desc;

  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              head_eop;
  logic              beat;

  // Grant must still be held for a beat to be taken; a dropped grant aborts.
  assign beat = (state == XFER) & head_valid & transfering;

  port_mux u_mux (
    .sel      (sel_q),
    .data_in  (port_data),
    .valid_in (port_valid),
    .eop_in   (port_eop),
    .pop_en   (beat),
    .data     (head_data),
    .valid    (head_valid),
    .eop      (head_eop),
    .pop      (port_pop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_q      <= '0;
      wr_ptr     <= '0;
      start_q    <= '0;
      cur_addr   <= '0;
      len        <= '0;
      err_q      <= 1'b0;
      desc       <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      pkt_done   <= 1'b0;
    end else begin
      sram_we  <= 1'b0;
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (transfering) begin
            sel_q    <= select;
            start_q  <= wr_ptr;
            cur_addr <= wr_ptr;
            len      <= '0;
            err_q    <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (!transfering) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (beat) begin
            sram_we    <= 1'b1;
            sram_addr  <= cur_addr;
            sram_wdata <= head_data;
            cur_addr   <= cur_addr + ADDR_W'(1);
            len        <= len + LEN_W'(1);
            // eop wins over truncation on the same beat
            if (head_eop) begin
              err_q <= 1'b0;
              state <= DONE;
            end else if (len == LEN_LAST) begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          pkt_done  <= 1'b1;
          desc.port <= sel_q;
          desc.addr <= start_q;
          desc.len  <= len;
          desc.err  <= err_q;
          wr_ptr    <= cur_addr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign pkt_port = desc.port;
  assign pkt_addr = desc.addr;
  assign pkt_len  = desc.len;
  assign pkt_err  = desc.err;

endmodule

// File: tb/tb_write_xfer_ctl.sv
// Directed bench for write_xfer_ctl with per-port FWFT FIFO models.
// Checks writes, descriptors, wrap, truncation, abort and async reset.
module tb_write_xfer_ctl;
  import sram_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [SEL_W-1:0] select;
  logic transfering;
  logic [NUM_PORTS*DATA_W-1:0] port_data = '0;
  logic [NUM_PORTS-1:0] port_valid = '0;
  logic [NUM_PORTS-1:0] port_eop = '0;
  logic [NUM_PORTS-1:0] port_pop;
  logic sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic busy;
  logic pkt_done;
  logic [SEL_W-1:0] pkt_port;
  logic [ADDR_W-1:0] pkt_addr;
  logic [LEN_W-1:0] pkt_len;
  logic pkt_err;

  write_xfer_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .select      (select),
    .transfering (transfering),
    .port_data   (port_data),
    .port_valid  (port_valid),
    .port_eop    (port_eop),
    .port_pop    (port_pop),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .pkt_port    (pkt_port),
    .pkt_addr    (pkt_addr),
    .pkt_len     (pkt_len),
    .pkt_err     (pkt_err)
  );

  always #5 clk = ~clk;

  // FIFO model storage: rings indexed by free-running head/tail
  logic [DATA_W-1:0] fd [NUM_PORTS][128];
  bit fe [NUM_PORTS][128];
  int hd [NUM_PORTS];
  int tl [NUM_PORTS];
  logic [NUM_PORTS-1:0] stall = '0;

  logic [NUM_PORTS-1:0] pop_seen = '0;
  logic [NUM_PORTS-1:0] pop_hist = '0;
  bit clr = 1'b0;
  bit multi = 1'b0;

  logic [ADDR_W-1:0] wa [256];
  logic [DATA_W-1:0] wd [256];
  int wn = 0;
  int dn = 0;
  logic [SEL_W-1:0] d_port;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0] d_len;
  logic d_err;

  int checks = 0;
  int failures = 0;
  int wbase;
  bit ok;

  initial begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  end

  always @(posedge clk) begin
    pop_seen <= port_pop;
    if (clr) pop_hist <= '0;
    else pop_hist <= pop_hist | port_pop;
    if ($countones(port_pop) > 1) multi <= 1'b1;
  end

  function automatic int hd_n(int i);
    return hd[i] + (pop_seen[i] ? 1 : 0);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop_seen[i]) hd[i] <= hd[i] + 1;
      port_valid[i] <= (hd_n(i) != tl[i]) && !stall[i];
      port_data[i*DATA_W +: DATA_W] <= fd[i][hd_n(i) & 127];
      port_eop[i] <= fe[i][hd_n(i) & 127];
    end
    if (sram_we) begin
      wa[wn & 255] <= sram_addr;
      wd[wn & 255] <= sram_wdata;
      wn <= wn + 1;
    end
    if (pkt_done) begin
      dn <= dn + 1;
      d_port <= pkt_port;
      d_addr <= pkt_addr;
      d_len <= pkt_len;
      d_err <= pkt_err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int p, input int n, input bit eop,
                      input logic [DATA_W-1:0] base);
    for (int k = 0; k < n; k++) begin
      fd[p][tl[p] & 127] = base + DATA_W'(k);
      fe[p][tl[p] & 127] = eop && (k == n - 1);
      tl[p] = tl[p] + 1;
    end
  endtask

  task automatic wait_done(output bit done);
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      if (pkt_done) begin
        done = 1'b1;
        transfering = 1'b0;
      end
    end
  endtask

  task automatic wait_wr(input int n, output bit got);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      if (wn - wbase >= n) got = 1'b1;
    end
  endtask

  task automatic run_pkt(input int p, input int n, input bit eop,
                         input logic [DATA_W-1:0] base);
    bit d;
    push(p, n, eop, base);
    wbase = wn;
    select = SEL_W'(p);
    transfering = 1'b1;
    wait_done(d);
    chk("done_timeout", 64'(d), 64'd1);
    step();
  endtask

  initial begin
    int rem;
    int n;
    int d0;
    rst = 1'b1;
    select = 4'd5;
    transfering = 1'b1;
    step();
    step();
    chk("rst_we", 64'(sram_we), 0);
    chk("rst_addr", 64'(sram_addr), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(pkt_done), 0);
    chk("rst_pop", 64'(port_pop), 0);
    transfering = 1'b0;
    rst = 1'b0;
    step();

    // basic packet on port 5
    push(5, 4, 1'b1, 32'hA0);
    wbase = wn;
    select = 4'd5;
    transfering = 1'b1;
    wait_done(ok);
    chk("basic_to", 64'(ok), 1);
    chk("basic_port", 64'(pkt_port), 5);
    chk("basic_addr", 64'(pkt_addr), 0);
    chk("basic_len", 64'(pkt_len), 4);
    chk("basic_err", 64'(pkt_err), 0);
    step();
    chk("basic_pulse", 64'(pkt_done), 0);
    chk("basic_nwr", 64'(wn - wbase), 4);
    for (int k = 0; k < 4; k++) begin
      chk("basic_wa", 64'(wa[(wbase + k) & 255]), 64'(k));
      chk("basic_wd", 64'(wd[(wbase + k) & 255]), 64'(32'hA0 + k));
    end

    // bubbles and select noise
    push(7, 2, 1'b1, 32'h70);
    push(2, 3, 1'b1, 32'hB0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    wbase = wn;
    select = 4'd2;
    transfering = 1'b1;
    step();
    step();
    step();
    stall[2] = 1'b1;
    select = 4'd7;
    step();
    step();
    stall[2] = 1'b0;
    wait_done(ok);
    chk("bub_to", 64'(ok), 1);
    chk("bub_port", 64'(pkt_port), 2);
    chk("bub_addr", 64'(pkt_addr), 4);
    chk("bub_len", 64'(pkt_len), 3);
    chk("bub_err", 64'(pkt_err), 0);
    step();
    chk("bub_hist", 64'(pop_hist), 64'(16'h0004));
    chk("bub_p7left", 64'(tl[7] - hd[7]), 2);
    chk("bub_wa2", 64'(wa[(wbase + 2) & 255]), 6);
    chk("bub_wd2", 64'(wd[(wbase + 2) & 255]), 64'h000000B2);

    // preload to 0xFFC; first 64-beat packet has eop on the truncation beat
    rem = 4092 - 7;
    d0 = dn;
    run_pkt(1, 64, 1'b1, 32'h100);
    chk("eop64_addr", 64'(d_addr), 7);
    chk("eop64_len", 64'(d_len), 64);
    chk("eop64_err", 64'(d_err), 0);
    rem = rem - 64;
    while (rem > 0) begin
      n = (rem > 64) ? 64 : rem;
      run_pkt(1, n, 1'b1, 32'h100);
      rem = rem - n;
    end
    chk("pre_cnt", 64'(dn - d0), 64);

    // address wrap
    run_pkt(3, 6, 1'b1, 32'hC0);
    chk("wrap_addr", 64'(d_addr), 64'hFFC);
    chk("wrap_len", 64'(d_len), 6);
    chk("wrap_wa3", 64'(wa[(wbase + 3) & 255]), 64'hFFF);
    chk("wrap_wa4", 64'(wa[(wbase + 4) & 255]), 0);
    chk("wrap_wa5", 64'(wa[(wbase + 5) & 255]), 1);

    // truncation: 70 beats, no eop
    run_pkt(0, 70, 1'b0, 32'h1000);
    chk("trunc_nwr", 64'(wn - wbase), 64);
    chk("trunc_addr", 64'(d_addr), 2);
    chk("trunc_len", 64'(d_len), 64);
    chk("trunc_err", 64'(d_err), 1);
    chk("trunc_left", 64'(tl[0] - hd[0]), 6);
    chk("trunc_last", 64'(wd[(wbase + 63) & 255]), 64'h103F);

    // abort after 2 beats
    push(4, 2, 1'b0, 32'hD0);
    wbase = wn;
    select = 4'd4;
    transfering = 1'b1;
    wait_wr(2, ok);
    chk("abort_wr_to", 64'(ok), 1);
    step();
    step();
    transfering = 1'b0;
    wait_done(ok);
    chk("abort_to", 64'(ok), 1);
    chk("abort_addr", 64'(pkt_addr), 64'h042);
    chk("abort_len", 64'(pkt_len), 2);
    chk("abort_err", 64'(pkt_err), 1);
    step();

    // zero-beat abort
    select = 4'd6;
    transfering = 1'b1;
    step();
    step();
    step();
    transfering = 1'b0;
    wait_done(ok);
    chk("zero_to", 64'(ok), 1);
    chk("zero_port", 64'(pkt_port), 6);
    chk("zero_len", 64'(pkt_len), 0);
    chk("zero_err", 64'(pkt_err), 1);
    step();
    run_pkt(8, 1, 1'b1, 32'hE0);
    chk("zero_ptr", 64'(d_addr), 64'h044);

    // async reset mid-packet
    push(9, 3, 1'b0, 32'hF0);
    wbase = wn;
    select = 4'd9;
    transfering = 1'b1;
    wait_wr(3, ok);
    chk("rstm_wr_to", 64'(ok), 1);
    step();
    d0 = dn;
    rst = 1'b1;
    #1;
    chk("rstm_addr", 64'(sram_addr), 0);
    chk("rstm_wdata", 64'(sram_wdata), 0);
    chk("rstm_busy", 64'(busy), 0);
    chk("rstm_pop", 64'(port_pop), 0);
    transfering = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("rstm_nodone", 64'(dn - d0), 0);
    run_pkt(10, 1, 1'b1, 32'h55);
    chk("rstm_next", 64'(d_addr), 0);
    chk("rstm_nport", 64'(d_port), 10);
    chk("onehot", 64'(multi), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
